smart_output_port_arbiter: RTL and testbench
============================================

// Module: smart_output_port_arbiter
// PURPOSE
//   Shares one router output link among the NUM_INPUTS input ports (EAST, SOUTH, WEST, NORTH, LOCAL order).
//   Each cycle it grants at most one requester, using round-robin priority gated by downstream credits.
//   The granted FlitFixed is registered onto the link.
//   One instance sits per output direction inside the mesh router, between the input buffers and the inter-router link.
// PARAMETERS
//   NUM_INPUTS    5    requesters; equals SMARTPkg::NUM_DIRECTIONS; index = Direction encoding
//   BUFFER_DEPTH  4    downstream input-buffer slots; this is the initial and maximum credit count
//   FLIT_WIDTH    33   $bits(SMARTPkg::FlitFixed)
// PORTS
//   clk             in   1                        clock
//   rst_n           in   1                        asynchronous active-low reset
//   port_enable     in   1                        0: no new grants; in-flight output still completes
//   req_valid       in   NUM_INPUTS               per-input head flit present
//   req_flit        in   NUM_INPUTS*FLIT_WIDTH    per-input head flit, input i at bits [i*FLIT_WIDTH +: FLIT_WIDTH]
//   req_grant       out  NUM_INPUTS               one-hot or zero, combinational; input pops its head flit this cycle
//   out_valid       out  1                        link flit valid (registered)
//   out_flit        out  FLIT_WIDTH               link flit (registered)
//   credit_in       in   1                        Credit: one downstream slot freed
//   credit_count    out  $clog2(BUFFER_DEPTH+1)   current credits available
//   credit_overflow out  1                        sticky error: credit returned while count==BUFFER_DEPTH
// BEHAVIOUR
//   Reset (async on rst_n low):
//     out_valid=0, out_flit=0, credit_count=BUFFER_DEPTH, credit_overflow=0, rr_ptr=0.
//     req_grant is 0 whenever rst_n is low.
//   Grant condition: port_enable && credit_count!=0 && |req_valid.
//   Grant selection:
//     - Round-robin search starts at index rr_ptr and wraps modulo NUM_INPUTS.
//     - The first valid requester found is granted; req_grant is one-hot at that index.
//   Output register (1-cycle latency):
//     - On grant, on the next edge: out_valid<=1, out_flit<=req_flit[g].
//     - With no grant: out_valid<=0 and out_flit holds its value.
//   Pointer update:
//     - On grant: rr_ptr<=(g+1)%NUM_INPUTS.
//     - No grant: rr_ptr holds.
//   Credit counter, per edge (grant = consume):
//     - grant & !credit_in : count-1
//     - !grant & credit_in : count+1, except at BUFFER_DEPTH, where the count saturates and credit_overflow<=1
//     - grant & credit_in  : count unchanged; never flags overflow
//     - neither            : count unchanged
//   Consumption is counted at grant, not when out_valid asserts, so count never underflows.
//   A credit arriving when count==0 allows a grant only from the following cycle; there is no same-cycle bypass.
//   port_enable=0 blocks grants only; credits keep accumulating.
//   Reset asserted mid-transfer: the registered flit is dropped and credits are restored.
//     The upstream/downstream pair is reset together by design.
// TESTING
//   1. Reset: all outputs at reset values; credit_count=4.
//      Single req_valid[2] with flit 33'h1_0000_00AA -> req_grant=5'b00100 same cycle; next cycle out_valid=1, out_flit=33'h1_0000_00AA, credit_count=3.
//   2. Fairness: all 5 req_valid held high, credit_in=1 every cycle.
//      -> grants cycle 0,1,2,3,4,0; credit_count stays 4; each input is granted exactly 2 times in 10 cycles.
//   3. Credit exhaustion: req_valid[0] held, no credit_in -> 4 grants, then credit_count=0 and req_grant=0.
//      Pulse credit_in once -> exactly one grant, occurring the cycle after the pulse.
//   4. Wrap: rr_ptr=4 (after a grant to 3), req_valid=5'b10001 -> grant 4, then grant 0.
//   5. Overflow: idle with count=4, pulse credit_in -> credit_overflow=1 (sticky), count stays 4.
//      Simultaneous grant+credit_in at count=4 -> no flag.
//   6. Async reset during a grant: rst_n low mid-cycle -> out_valid=0, credit_count=4, credit_overflow=0 immediately; the next grant after release is to the lowest valid index.

Source files
------------

// File: rtl/smart_output_port_arbiter.sv
// smart_output_port_arbiter: credit-gated round-robin arbiter driving one registered router output link
module smart_output_port_arbiter #(
    parameter  int NUM_INPUTS   = 5,
    parameter  int BUFFER_DEPTH = 4,
    parameter  int FLIT_WIDTH   = 33,
    localparam int CW           = $clog2(BUFFER_DEPTH + 1),
    localparam int PW           = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             port_enable,
    input  logic [NUM_INPUTS-1:0]            req_valid,
    input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] req_flit,
    output logic [NUM_INPUTS-1:0]            req_grant,
    output logic                             out_valid,
    output logic [FLIT_WIDTH-1:0]            out_flit,
    input  logic                             credit_in,
    output logic [CW-1:0]                    credit_count,
    output logic                             credit_overflow
);
    localparam logic [CW-1:0] MAX_CREDIT = CW'(BUFFER_DEPTH);

    logic [PW-1:0]         rr_ptr_q, rr_ptr_d, grant_idx, idx;
    logic                  found, grant;
    logic [CW-1:0]         credit_q, credit_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
    logic                  consume_only, return_only;

    // Search from rr_ptr upward with wrap; the first valid requester wins
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = PW'((int'(rr_ptr_q) + k) % NUM_INPUTS);
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Credits are consumed at grant time, so an empty counter blocks the grant itself
    assign grant        = rst_n && port_enable && (credit_q != '0) && found;
    assign req_grant    = grant ? (NUM_INPUTS'(1) << grant_idx) : '0;
    assign consume_only = grant && !credit_in;
    assign return_only  = !grant && credit_in;

    // Next-state for pointer, output register and credit bookkeeping
    always_comb begin
        rr_ptr_d    = grant ? PW'((int'(grant_idx) + 1) % NUM_INPUTS) : rr_ptr_q;
        out_valid_d = grant;
        out_flit_d  = grant ? req_flit[int'(grant_idx)*FLIT_WIDTH +: FLIT_WIDTH] : out_flit_q;
        credit_d    = consume_only                               ? credit_q - CW'(1) :
                      (return_only && credit_q != MAX_CREDIT)    ? credit_q + CW'(1) :
                                                                   credit_q;
        ovf_d       = ovf_q || (return_only && credit_q == MAX_CREDIT);
    end

    // State registers; reset drops any in-flight flit and restores full credit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            credit_q    <= MAX_CREDIT;
            ovf_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            credit_q    <= credit_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_flit        = out_flit_q;
    assign credit_count    = credit_q;
    assign credit_overflow = ovf_q;
endmodule

// File: tb/tb_smart_output_port_arbiter.sv
// tb_smart_output_port_arbiter: directed stimulus with a per-cycle behavioural model check
module tb_smart_output_port_arbiter;
    localparam int N  = 5;
    localparam int D  = 4;
    localparam int FW = 33;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            port_enable = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*FW-1:0] req_flit = {33'h0_1234_5004, 33'h1_CAFE_0003, 33'h1_0000_00AA, 33'h0_BEEF_0001, 33'h1_5555_0000};
    logic [N-1:0]    req_grant;
    logic            out_valid;
    logic [FW-1:0]   out_flit;
    logic            credit_in = 1'b0;
    logic [2:0]      credit_count;
    logic            credit_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    smart_output_port_arbiter #(.NUM_INPUTS(N), .BUFFER_DEPTH(D), .FLIT_WIDTH(FW)) dut (
        .clk(clk), .rst_n(rst_n), .port_enable(port_enable), .req_valid(req_valid),
        .req_flit(req_flit), .req_grant(req_grant), .out_valid(out_valid), .out_flit(out_flit),
        .credit_in(credit_in), .credit_count(credit_count), .credit_overflow(credit_overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: pointer, credit count, sticky flag and the registered link
    int            m_ptr  = 0;
    int            m_cred = D;
    logic          m_ovf  = 1'b0;
    logic          m_ov   = 1'b0;
    logic [FW-1:0] m_flit = '0;
    int            m_grant;

    always_comb begin
        m_grant = -1;
        if (rst_n && port_enable && m_cred > 0)
            for (int k = 0; k < N; k++)
                if (m_grant < 0 && req_valid[(m_ptr + k) % N]) m_grant = (m_ptr + k) % N;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr  <= 0;
            m_cred <= D;
            m_ovf  <= 1'b0;
            m_ov   <= 1'b0;
            m_flit <= '0;
        end else begin
            m_ov <= (m_grant >= 0);
            if (m_grant >= 0) begin
                m_flit <= req_flit[m_grant*FW +: FW];
                m_ptr  <= (m_grant + 1) % N;
            end
            if (m_grant >= 0 && !credit_in) m_cred <= m_cred - 1;
            else if (m_grant < 0 && credit_in) begin
                if (m_cred == D) m_ovf <= 1'b1;
                else m_cred <= m_cred + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge
    initial forever begin
        @(negedge clk);
        chk("model_grant", 64'(req_grant), m_grant < 0 ? 64'd0 : (64'd1 << m_grant));
        chk("model_out_valid", 64'(out_valid), 64'(m_ov));
        chk("model_out_flit", 64'(out_flit), 64'(m_flit));
        chk("model_credit", 64'(credit_count), 64'(m_cred));
        chk("model_overflow", 64'(credit_overflow), 64'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        req_valid = '0;
        credit_in = 1'b0;
        port_enable = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    int cnt[N];
    int g;

    initial begin
        step();
        step();
        rst_n = 1'b1;
        // 1: reset state and single request
        @(negedge clk);
        chk("t1_rst_credit", 64'(credit_count), 64'd4);
        chk("t1_rst_valid", 64'(out_valid), 64'd0);
        chk("t1_rst_flit", 64'(out_flit), 64'd0);
        chk("t1_rst_ovf", 64'(credit_overflow), 64'd0);
        step();
        req_valid = 5'b00100;
        @(negedge clk);
        chk("t1_grant", 64'(req_grant), 64'b00100);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_flit", 64'(out_flit), 64'h1_0000_00AA);
        chk("t1_credit", 64'(credit_count), 64'd3);
        // 2: fairness with all requesting and a credit every cycle
        do_reset();
        req_valid = 5'h1F;
        credit_in = 1'b1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t2_rr_order", 64'(req_grant), 64'd1 << (c % N));
            for (int i = 0; i < N; i++) cnt[i] += int'(req_grant[i]);
        end
        step();
        req_valid = '0;
        credit_in = 1'b0;
        @(negedge clk);
        chk("t2_credit", 64'(credit_count), 64'd4);
        for (int i = 0; i < N; i++) chk("t2_count", 64'(cnt[i]), 64'd2);
        // 3: credit exhaustion and single-credit refill without bypass
        do_reset();
        req_valid = 5'b00001;
        g = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            g += int'(req_grant[0]);
        end
        chk("t3_grants", 64'(g), 64'd4);
        chk("t3_credit0", 64'(credit_count), 64'd0);
        chk("t3_blocked", 64'(req_grant), 64'd0);
        step();
        credit_in = 1'b1;
        @(negedge clk);
        chk("t3_no_bypass", 64'(req_grant), 64'd0);
        step();
        credit_in = 1'b0;
        @(negedge clk);
        chk("t3_refill_grant", 64'(req_grant), 64'b00001);
        step();
        @(negedge clk);
        chk("t3_after", 64'(req_grant), 64'd0);
        chk("t3_credit_after", 64'(credit_count), 64'd0);
        // port disabled: no grants, credits still accumulate
        step();
        port_enable = 1'b0;
        credit_in = 1'b1;
        req_valid = 5'h1F;
        @(negedge clk);
        chk("t3_disabled", 64'(req_grant), 64'd0);
        step();
        credit_in = 1'b0;
        @(negedge clk);
        chk("t3_disabled2", 64'(req_grant), 64'd0);
        chk("t3_disabled_credit", 64'(credit_count), 64'd1);
        step();
        port_enable = 1'b1;
        req_valid = '0;
        // 4: pointer wrap from 4 back to 0
        do_reset();
        req_valid = 5'b01000;
        @(negedge clk);
        chk("t4_g3", 64'(req_grant), 64'b01000);
        step();
        req_valid = 5'b10001;
        @(negedge clk);
        chk("t4_g4", 64'(req_grant), 64'b10000);
        step();
        @(negedge clk);
        chk("t4_g0", 64'(req_grant), 64'b00001);
        step();
        req_valid = '0;
        // 5: overflow is sticky; grant with credit at full count does not flag
        do_reset();
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        @(negedge clk);
        chk("t5_ovf", 64'(credit_overflow), 64'd1);
        chk("t5_credit", 64'(credit_count), 64'd4);
        step();
        @(negedge clk);
        chk("t5_sticky", 64'(credit_overflow), 64'd1);
        do_reset();
        req_valid = 5'b00001;
        credit_in = 1'b1;
        @(negedge clk);
        chk("t5_grant", 64'(req_grant), 64'b00001);
        step();
        req_valid = '0;
        credit_in = 1'b0;
        @(negedge clk);
        chk("t5_no_ovf", 64'(credit_overflow), 64'd0);
        chk("t5_credit2", 64'(credit_count), 64'd4);
        // 6: asynchronous reset in the middle of a transfer
        do_reset();
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        req_valid = 5'b00100;
        @(negedge clk);
        chk("t6_grant", 64'(req_grant), 64'b00100);
        step();
        req_valid = 5'b01010;
        @(negedge clk);
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        chk("t6_pre_ovf", 64'(credit_overflow), 64'd1);
        chk("t6_pre_credit", 64'(credit_count), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_credit", 64'(credit_count), 64'd4);
        chk("t6_rst_ovf", 64'(credit_overflow), 64'd0);
        chk("t6_rst_grant", 64'(req_grant), 64'd0);
        chk("t6_rst_flit", 64'(out_flit), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_lowest", 64'(req_grant), 64'b00010);
        step();
        req_valid = '0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
